// File: rtl/audio_frame_sched_pkg.sv
// Shared definitions for the audio frame scheduler.
//   ACC_GUARD      : headroom bits added above the sample width in the mix
//                    accumulator (W+3 holds the sum of up to 8 full-scale samples)
//   sched_state_e  : mixer FSM encoding (IDLE=0, ACC=1, PUB=2)
package audio_frame_sched_pkg;

    localparam int ACC_GUARD = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_PUB  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/audio_frame_sched_if.sv
// Source/encoder bundle of the audio frame scheduler.
//   src_valid/src_ready : per-source handshake. A sample moves on a rising edge
//                         where valid & ready are both high. Ready is a registered
//                         "slot empty" flag and never depends on valid. A source
//                         may raise or drop valid at any time.
//   src_l/src_r         : per-source samples, source i at [i*W +: W]
//   mute                : per-source mute (slot is still consumed)
//   l/r/frame           : mixed pair to the encoder; frame pulses when l/r change
//   underrun            : per-source pulse, slot was empty at the frame tick
// master = sources/encoder side (testbench), slave = scheduler.
interface audio_frame_sched_if #(
    parameter int NSRC = 3,
    parameter int W    = 16
);
    logic [NSRC-1:0]   src_valid;
    logic [NSRC-1:0]   src_ready;
    logic [NSRC*W-1:0] src_l;
    logic [NSRC*W-1:0] src_r;
    logic [NSRC-1:0]   mute;
    logic [W-1:0]      l;
    logic [W-1:0]      r;
    logic              frame;
    logic [NSRC-1:0]   underrun;

    modport master (
        output src_valid, src_l, src_r, mute,
        input  src_ready, l, r, frame, underrun
    );

    modport slave (
        input  src_valid, src_l, src_r, mute,
        output src_ready, l, r, frame, underrun
    );
endinterface

// File: rtl/audio_frame_sched_sat.sv
// Combinational clamp of a signed ACC_W-bit accumulator to a signed W-bit word.
//   acc_i : signed accumulator value
//   sat_o : value clamped to [-2^(W-1), 2^(W-1)-1]
module audio_frame_sched_sat #(
    parameter int W     = 16,
    parameter int ACC_W = W + 3
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [W-1:0]     sat_o
);
    logic ovf;

    always_comb begin
        // The value fits in W bits only if every bit from the W-bit sign
        // position upward equals the accumulator sign bit.
        ovf = (acc_i[ACC_W-1:W-1] != {(ACC_W-W+1){acc_i[ACC_W-1]}});
        if (!ovf) begin
            sat_o = acc_i[W-1:0];
        end else if (acc_i[ACC_W-1]) begin
            sat_o = {1'b1, {(W-1){1'b0}}};
        end else begin
            sat_o = {1'b0, {(W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/audio_frame_sched.sv
// Frame-rate audio scheduler and mixer in front of the I2S encoder.
// Holds one stereo sample per source, snapshots all slots at each frame tick,
// then mixes the snapshot through a single shared adder (one source per cycle)
// and publishes a saturated l/r pair that stays stable for the rest of the frame.
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus            : source handshakes, mute, mixed output and underrun pulses
//   dbg_state_o    : current mixer FSM state
module audio_frame_sched
    import audio_frame_sched_pkg::*;
#(
    parameter int NSRC      = 3,
    parameter int W         = 16,
    parameter int FRAME_DIV = 1024
) (
    input  logic                clock,
    input  logic                reset_n,
    audio_frame_sched_if.slave  bus,
    output sched_state_e        dbg_state_o
);
    localparam int ACC_W = W + ACC_GUARD;
    localparam int CW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int IW    = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NSRC - 1);

    // frame counter
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    // holding slots and the staging bank used by the mix
    logic [NSRC-1:0]         full_q, full_d;
    logic [NSRC-1:0][W-1:0]  slot_l_q, slot_l_d, slot_r_q, slot_r_d;
    logic [NSRC-1:0]         stage_full_q, stage_full_d;
    logic [NSRC-1:0][W-1:0]  stage_l_q, stage_l_d, stage_r_q, stage_r_d;
    logic [NSRC-1:0]         underrun_q, underrun_d;
    logic [NSRC-1:0]         xfer;

    // mixer
    sched_state_e     state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [ACC_W-1:0] add_l, add_r, sum_l, sum_r;
    logic [W-1:0]     sel_l, sel_r, sat_l, sat_r;
    logic             use_src;
    logic [W-1:0]     l_q, l_d, r_q, r_d;

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // Ready is the registered inverse of full, so it never depends on valid.
    assign xfer = bus.src_valid & ~full_q;

    always_comb begin
        // A transfer in the tick cycle lands in the freshly emptied slot and
        // belongs to the next frame; the snapshot below takes the old contents.
        full_d   = tick ? xfer : (full_q | xfer);
        slot_l_d = slot_l_q;
        slot_r_d = slot_r_q;
        for (int i = 0; i < NSRC; i++) begin
            if (xfer[i]) begin
                slot_l_d[i] = bus.src_l[i*W +: W];
                slot_r_d[i] = bus.src_r[i*W +: W];
            end
        end
        stage_full_d = tick ? full_q   : stage_full_q;
        stage_l_d    = tick ? slot_l_q : stage_l_q;
        stage_r_d    = tick ? slot_r_q : stage_r_q;
        underrun_d   = tick ? ~full_q  : '0;
    end

    // Shared adder: one staged source per ACC cycle, sign-extended to ACC_W.
    always_comb begin
        sel_l   = stage_l_q[idx_q];
        sel_r   = stage_r_q[idx_q];
        use_src = stage_full_q[idx_q] & ~bus.mute[idx_q];
        add_l   = use_src ? {{ACC_GUARD{sel_l[W-1]}}, sel_l} : '0;
        add_r   = use_src ? {{ACC_GUARD{sel_r[W-1]}}, sel_r} : '0;
        sum_l   = acc_l_q + add_l;
        sum_r   = acc_r_q + add_r;
    end

    audio_frame_sched_sat #(.W(W), .ACC_W(ACC_W)) u_sat_l (.acc_i(sum_l), .sat_o(sat_l));
    audio_frame_sched_sat #(.W(W), .ACC_W(ACC_W)) u_sat_r (.acc_i(sum_r), .sat_o(sat_r));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        l_d     = l_q;
        r_d     = r_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_ACC;
                    idx_d   = '0;
                    acc_l_d = '0;
                    acc_r_d = '0;
                end
            end
            ST_ACC: begin
                acc_l_d = sum_l;
                acc_r_d = sum_r;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    // l/r are loaded on entry to PUB so they change exactly in
                    // the cycle frame is high, NSRC+1 cycles after the tick.
                    state_d = ST_PUB;
                    idx_d   = '0;
                    l_d     = sat_l;
                    r_d     = sat_r;
                end
            end
            ST_PUB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            full_q       <= '0;
            slot_l_q     <= '0;
            slot_r_q     <= '0;
            stage_full_q <= '0;
            stage_l_q    <= '0;
            stage_r_q    <= '0;
            underrun_q   <= '0;
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            l_q          <= '0;
            r_q          <= '0;
        end else begin
            cnt_q        <= cnt_d;
            full_q       <= full_d;
            slot_l_q     <= slot_l_d;
            slot_r_q     <= slot_r_d;
            stage_full_q <= stage_full_d;
            stage_l_q    <= stage_l_d;
            stage_r_q    <= stage_r_d;
            underrun_q   <= underrun_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_l_q      <= acc_l_d;
            acc_r_q      <= acc_r_d;
            l_q          <= l_d;
            r_q          <= r_d;
        end
    end

    assign bus.src_ready = ~full_q;
    assign bus.l         = l_q;
    assign bus.r         = r_q;
    assign bus.frame     = (state_q == ST_PUB);
    assign bus.underrun  = underrun_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_audio_frame_sched.sv
module tb_audio_frame_sched;
  import audio_frame_sched_pkg::*;

  localparam int NSRC = 3;
  localparam int W    = 16;
  localparam int FD   = 64;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  audio_frame_sched_if #(.NSRC(NSRC), .W(W)) bus ();
  sched_state_e dbg_state;

  audio_frame_sched #(.NSRC(NSRC), .W(W), .FRAME_DIV(FD)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  int cyc;
  int m_cnt;
  bit m_full[NSRC];
  int m_l[NSRC];
  int m_r[NSRC];
  logic [NSRC-1:0] m_under;
  logic [NSRC-1:0] mute_v;
  logic [W-1:0] cur_l, cur_r, prev_l, prev_r;
  int pub_cyc_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r_q[$];
  int ticks = 0;
  int frames = 0;
  logic [NSRC-1:0] under_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] clamp(input int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return W'(v);
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_cnt = 0;
    for (int i = 0; i < NSRC; i++) m_full[i] = 0;
    m_under = '0;
    cur_l = '0; cur_r = '0; prev_l = '0; prev_r = '0;
    // a mix cut short by reset never publishes
    ticks -= pub_cyc_q.size();
    pub_cyc_q.delete(); exp_q.delete(); exp_r_q.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic [NSRC-1:0] v, input logic [NSRC*W-1:0] dl,
                      input logic [NSRC*W-1:0] dr);
    logic [NSRC-1:0] exp_ready, xfer;
    logic exp_frame, drift;
    int sl, sr;
    @(negedge clock);
    exp_frame = 1'b0;
    if (pub_cyc_q.size() > 0 && pub_cyc_q[0] == cyc) begin
      void'(pub_cyc_q.pop_front());
      cur_l = exp_q.pop_front();
      cur_r = exp_r_q.pop_front();
      exp_frame = 1'b1;
    end
    for (int i = 0; i < NSRC; i++) exp_ready[i] = !m_full[i];
    check("ready", bus.src_ready, exp_ready);
    check("l", bus.l, cur_l);
    check("r", bus.r, cur_r);
    check("frame", bus.frame, exp_frame);
    check("underrun", bus.underrun, m_under);
    drift = ((bus.l !== prev_l) || (bus.r !== prev_r)) && (bus.frame !== 1'b1);
    check("stable", drift, 1'b0);
    prev_l = bus.l; prev_r = bus.r;
    if (bus.frame === 1'b1) frames++;
    under_seen |= bus.underrun;

    bus.src_valid = v;
    bus.src_l = dl;
    bus.src_r = dr;
    bus.mute = mute_v;

    xfer = v & exp_ready;
    if (m_cnt == FD - 1) begin
      ticks++;
      sl = 0; sr = 0;
      for (int i = 0; i < NSRC; i++) begin
        m_under[i] = !m_full[i];
        if (m_full[i] && !mute_v[i]) begin
          sl += m_l[i];
          sr += m_r[i];
        end
        m_full[i] = 0;
      end
      pub_cyc_q.push_back(cyc + NSRC + 1);
      exp_q.push_back(clamp(sl));
      exp_r_q.push_back(clamp(sr));
    end else begin
      m_under = '0;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (xfer[i]) begin
        m_full[i] = 1;
        m_l[i] = int'($signed(dl[i*W +: W]));
        m_r[i] = int'($signed(dr[i*W +: W]));
      end
    end
    m_cnt = (m_cnt == FD - 1) ? 0 : m_cnt + 1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0);
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_cnt != target && guard < 2 * FD) begin
      step('0, '0, '0);
      guard++;
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_l"}, bus.l, '0);
    check({tag, "_r"}, bus.r, '0);
    check({tag, "_frame"}, bus.frame, 1'b0);
    check({tag, "_ready"}, bus.src_ready, {NSRC{1'b1}});
    check({tag, "_under"}, bus.underrun, '0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [NSRC-1:0] v;
    logic [NSRC*W-1:0] dl, dr;
    int f0, t0;

    bus.src_valid = '0; bus.src_l = '0; bus.src_r = '0; bus.mute = '0;
    mute_v = '0;
    under_seen = '0;
    model_reset();

    // reset state
    repeat (3) @(posedge clock);
    #1 reset_checks("rst0");
    @(posedge clock);
    #1 reset_n = 1'b1;

    // basic mix
    step(3'b111, {16'hFF00, 16'h0200, 16'h1000}, {16'h0003, 16'h0002, 16'h0001});
    idle(FD + 8);
    check("mix_l", bus.l, 16'h1100);
    check("mix_r", bus.r, 16'h0006);
    check("mix_frames", frames, 1);

    // saturation both ways
    step(3'b111, {16'h7000, 16'h7000, 16'h7000}, {16'h9000, 16'h9000, 16'h9000});
    idle(FD + 8);
    check("sat_hi_l", bus.l, 16'h7FFF);
    check("sat_lo_r", bus.r, 16'h8000);
    step(3'b111, {16'h9000, 16'h9000, 16'h9000}, {16'h0100, 16'h0100, 16'h0100});
    idle(FD + 8);
    check("sat_lo_l", bus.l, 16'h8000);
    check("sat_r", bus.r, 16'h0300);

    // underrun + mute
    mute_v = 3'b100;
    under_seen = '0;
    step(3'b101, {16'h4000, 16'h0000, 16'h0010}, {16'h4000, 16'h0000, 16'hFFF0});
    idle(FD + 8);
    check("mute_l", bus.l, 16'h0010);
    check("mute_r", bus.r, 16'hFFF0);
    check("under_once", under_seen, 3'b010);
    mute_v = '0;

    // reset asserted in the middle of a mix
    step(3'b111, {16'h0100, 16'h0100, 16'h0100}, {16'h0100, 16'h0100, 16'h0100});
    run_to(2);
    check("pre_rst_acc", dbg_state, ST_ACC);
    #1 reset_n = 1'b0;
    #1 reset_checks("rst_acc");
    repeat (2) @(negedge clock);
    reset_checks("rst_hold");
    @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();

    // transfer in the tick cycle goes to the next frame
    run_to(FD - 1);
    step(3'b001, {16'h0, 16'h0, 16'h0123}, {16'h0, 16'h0, 16'h0456});
    idle(6);
    check("edge_excl_l", bus.l, 16'h0000);
    check("edge_ready0", bus.src_ready[0], 1'b0);
    idle(FD);
    check("edge_next_l", bus.l, 16'h0123);
    check("edge_next_r", bus.r, 16'h0456);

    // random traffic, 50 frames
    f0 = frames; t0 = ticks;
    for (int k = 0; k < 50 * FD; k++) begin
      if (m_cnt == FD / 2) mute_v = NSRC'($urandom_range(0, 7)) & NSRC'($urandom_range(0, 7));
      v = ($urandom_range(0, 15) == 0) ? NSRC'($urandom) : '0;
      for (int i = 0; i < NSRC; i++) begin
        dl[i*W +: W] = W'($urandom);
        dr[i*W +: W] = W'($urandom);
      end
      step(v, dl, dr);
    end
    mute_v = '0;
    idle(NSRC + 4);
    check("rand_frames", frames - f0, 50);
    check("frame_vs_tick", frames, ticks);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
